mem_responder: RTL and testbench

//   Word-addressed 32-bit memory target that services instruction fetch, load and store requests.
//   The requests come from the multicycle CPU core over a valid/ready request + valid/ready response handshake.

---
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory target with programmable wait states and an out-of-range error response.
// One request is outstanding at a time: IDLE accepts, WAIT counts wait states, RESP holds the response.
module mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);
    // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where resp_valid && resp_ready. The
    // responder holds resp_* stable until its response has transferred.

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_cnt;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_req_in_range;
    logic        w_src_we;
    logic [31:0] w_src_addr;
    logic        w_src_in_range;
    logic [31:0] w_rd_word;
    logic        w_enter_resp;

    // Full 32-bit compare so high address bits never alias into the array.
    assign w_req_in_range = (req_addr < DEPTH_W);
    assign w_accept       = req_valid && (r_state == ST_IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = (LATENCY > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = r_resp_valid;
        resp_rdata = r_resp_rdata;
        resp_err   = r_resp_err;
        dbg_state  = r_state;
    end

    // With zero wait states RESP is entered straight from IDLE, so the response
    // must be built from the live request rather than the latched copy.
    always_comb begin
        w_src_we   = r_we;
        w_src_addr = r_addr;
        if (r_state == ST_IDLE) begin
            w_src_we   = req_we;
            w_src_addr = req_addr;
        end
    end

    assign w_src_in_range = (w_src_addr < DEPTH_W);
    assign w_rd_word      = r_mem[w_src_addr[AW-1:0]];
    assign w_enter_resp   = (w_next_state == ST_RESP) && (r_state != ST_RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we   <= req_we;
                r_addr <= req_addr;
                r_cnt  <= CNT_INIT;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= (!w_src_we && w_src_in_range) ? w_rd_word : 32'd0;
                r_resp_err   <= !w_src_in_range;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_resp_valid <= 1'b0;
                r_resp_err   <= 1'b0;
            end
        end
    end

    // Stores commit on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && w_req_in_range) begin
            r_mem[req_addr[AW-1:0]] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none,
// directed vector table, multi-cycle corner sequences and randomized traffic.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 2;
    localparam int LAT1  = 0;

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_ready [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic [1:0]  dbg_state  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference memory: what each address should hold, and whether it was ever written.
    logic [31:0] m_mem [2][DEPTH];
    bit          m_vld [2][DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic        early;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_we     (req_we[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0]),
        .dbg_state  (dbg_state[0])
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_we     (req_we[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1]),
        .dbg_state  (dbg_state[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Transaction-level model: error if out of range, stores update, loads return last store.
    task automatic model_txn(input int s, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] exp_rdata,
                             output logic exp_err, output bit known);
        exp_err   = (addr >= 32'(DEPTH));
        exp_rdata = 32'd0;
        known     = 1'b1;
        if (!exp_err) begin
            if (we) begin
                m_mem[s][int'(addr)] = wdata;
                m_vld[s][int'(addr)] = 1'b1;
            end else begin
                exp_rdata = m_mem[s][int'(addr)];
                known     = m_vld[s][int'(addr)];
            end
        end
    endtask

    // Called at a falling edge with the target idle. Issues one request, measures the
    // accept-to-response latency, optionally stalls resp_ready and checks the response holds.
    task automatic do_txn(input int s, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input logic early,
                          output logic [31:0] got_rdata, output logic got_err);
        int lat;
        req_valid[s]  = 1'b1;
        req_we[s]     = we;
        req_addr[s]   = addr;
        req_wdata[s]  = wdata;
        resp_ready[s] = early;
        check("req_ready_idle", 32'(req_ready[s]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
        lat = 1;
        while (!resp_valid[s] && lat < 40) begin
            check("req_ready_busy", 32'(req_ready[s]), 32'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), (s == 0) ? 32'(LAT0 + 1) : 32'(LAT1 + 1));
        got_rdata = resp_rdata[s];
        got_err   = resp_err[s];
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                check("hold_valid", 32'(resp_valid[s]), 32'd1);
                check("hold_rdata", resp_rdata[s], got_rdata);
                check("hold_err", 32'(resp_err[s]), 32'(got_err));
                check("hold_req_ready", 32'(req_ready[s]), 32'd0);
            end
            resp_ready[s] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        resp_ready[s] = 1'b0;
        check("post_resp_valid", 32'(resp_valid[s]), 32'd0);
        check("post_resp_err", 32'(resp_err[s]), 32'd0);
        check("post_req_ready", 32'(req_ready[s]), 32'd1);
        check("post_state_idle", 32'(dbg_state[s]), 32'd0);
    endtask

    initial begin
        logic [31:0] got_rdata;
        logic        got_err;
        logic [31:0] exp_rdata;
        logic        exp_err;
        bit          known;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_exp  [4];
        int          acc_cyc  [4];
        int          acc;
        int          rsp;
        int          cyc;
        int          r;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;

        //            we    addr           wdata          hold early exp_rdata      exp_err
        vecs[0] = '{1'b1, 32'd5,         32'hDEADBEEF, 0, 1'b0, 32'd0,         1'b0};
        vecs[1] = '{1'b0, 32'd5,         32'd0,        0, 1'b0, 32'hDEADBEEF,  1'b0};
        vecs[2] = '{1'b1, 32'd1023,      32'hA5A50001, 1, 1'b0, 32'd0,         1'b0};
        vecs[3] = '{1'b0, 32'd1023,      32'd0,        5, 1'b0, 32'hA5A50001,  1'b0};
        vecs[4] = '{1'b0, 32'd1024,      32'd0,        2, 1'b0, 32'd0,         1'b1};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h1,        0, 1'b1, 32'd0,         1'b1};
        vecs[6] = '{1'b0, 32'h3FF,       32'd0,        0, 1'b0, 32'hA5A50001,  1'b0};
        vecs[7] = '{1'b1, 32'h0000_1005, 32'h55,       0, 1'b0, 32'd0,         1'b1};
        vecs[8] = '{1'b0, 32'd5,         32'd0,        0, 1'b1, 32'hDEADBEEF,  1'b0};
        vecs[9] = '{1'b0, 32'h8000_0000, 32'd0,        3, 1'b0, 32'd0,         1'b1};

        for (int s = 0; s < 2; s++) begin
            req_valid[s]  = 1'b0;
            req_we[s]     = 1'b0;
            req_addr[s]   = 32'd0;
            req_wdata[s]  = 32'd0;
            resp_ready[s] = 1'b0;
        end

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            check("rst_req_ready", 32'(req_ready[s]), 32'd1);
            check("rst_resp_valid", 32'(resp_valid[s]), 32'd0);
            check("rst_resp_rdata", resp_rdata[s], 32'd0);
            check("rst_resp_err", 32'(resp_err[s]), 32'd0);
            check("rst_state", 32'(dbg_state[s]), 32'd0);
        end

        // Directed vectors, including stalled responses and out-of-range stores.
        for (int i = 0; i < 10; i++) begin
            model_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, exp_rdata, exp_err, known);
            do_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold, vecs[i].early,
                   got_rdata, got_err);
            check("vec_rdata", got_rdata, vecs[i].exp_rdata);
            check("vec_err", 32'(got_err), 32'(vecs[i].exp_err));
        end

        // Reset while a store is waiting: response dropped, store stays committed.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'd7;
        req_wdata[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        model_txn(0, 1'b1, 32'd7, 32'h12345678, exp_rdata, exp_err, known);
        check("t5_in_wait", 32'(dbg_state[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("t5_state_idle", 32'(dbg_state[0]), 32'd0);
        check("t5_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("t5_req_ready", 32'(req_ready[0]), 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t5_no_late_resp", 32'(resp_valid[0]), 32'd0);
        do_txn(0, 1'b0, 32'd7, 32'd0, 0, 1'b0, got_rdata, got_err);
        check("t5_load_rdata", got_rdata, 32'h12345678);
        check("t5_load_err", 32'(got_err), 32'd0);

        // Reset while a response is being held.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'd2000;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        cyc = 0;
        while (!resp_valid[0] && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("rr_resp_err", 32'(resp_err[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rr_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rr_resp_err_clr", 32'(resp_err[0]), 32'd0);
        check("rr_req_ready", 32'(req_ready[0]), 32'd1);

        // Zero wait states: preload, then four loads with req_valid held high.
        for (int i = 0; i < 4; i++) begin
            b2b_addr[i] = 32'(100 + i);
            wdata = $urandom;
            model_txn(1, 1'b1, b2b_addr[i], wdata, exp_rdata, exp_err, known);
            do_txn(1, 1'b1, b2b_addr[i], wdata, 0, 1'b0, got_rdata, got_err);
            check("b2b_pre_err", 32'(got_err), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            model_txn(1, 1'b0, b2b_addr[i], 32'd0, b2b_exp[i], exp_err, known);
        end
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b0;
        req_addr[1]   = b2b_addr[0];
        resp_ready[1] = 1'b1;
        acc = 0;
        rsp = 0;
        cyc = 0;
        while (rsp < 4 && cyc < 40) begin
            if (resp_valid[1]) begin
                check("b2b_rdata", resp_rdata[1], b2b_exp[rsp]);
                rsp++;
            end
            if (req_ready[1] && acc < 4) begin
                acc_cyc[acc] = cyc;
                acc++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc < 4) req_addr[1] = b2b_addr[acc];
            else req_valid[1] = 1'b0;
        end
        resp_ready[1] = 1'b0;
        check("b2b_resp_count", 32'(rsp), 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("b2b_accept_spacing", 32'(acc_cyc[i + 1] - acc_cyc[i]), 32'd2);
        end
        @(negedge clk);
        check("b2b_state_idle", 32'(dbg_state[1]), 32'd0);

        // Randomized traffic on both instances against the reference model.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 40; n++) begin
                we = 1'($urandom_range(0, 1));
                r  = $urandom_range(0, 9);
                if (r < 6) addr = 32'($urandom_range(0, 15));
                else if (r < 8) addr = 32'(DEPTH - $urandom_range(1, 4));
                else addr = $urandom | 32'h0000_0400;
                wdata = $urandom;
                model_txn(s, we, addr, wdata, exp_rdata, exp_err, known);
                do_txn(s, we, addr, wdata, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       got_rdata, got_err);
                check("rnd_err", 32'(got_err), 32'(exp_err));
                if (known) check("rnd_rdata", got_rdata, exp_rdata);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
